// File: rtl/abr_mem_copy_engine.sv
// Memory copy/zero-fill engine: streams len words from a source SRAM port to a
// destination SRAM port through a two-stage write pipeline, one word per cycle.
module abr_mem_copy_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 96,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              zero_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic              src_rd_en_o,
  output logic [ADDR_W-1:0] src_addr_o,
  input  logic [DATA_W-1:0] src_rd_data_i,
  output logic              dst_we_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic [DATA_W-1:0] dst_wdata_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [LEN_W-1:0]  ONE_L = 1;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              zero_q, zero_d;
  logic [ADDR_W-1:0] src_base_q, src_base_d;
  logic [ADDR_W-1:0] dst_base_q, dst_base_d;
  logic              drain_q, drain_d;
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_off_q, s1_off_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              src_rd_en_q, src_rd_en_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic              dst_we_q, dst_we_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [DATA_W-1:0] dst_wdata_q, dst_wdata_d;

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    len_d       = len_q;
    zero_d      = zero_q;
    src_base_d  = src_base_q;
    dst_base_d  = dst_base_q;
    drain_d     = drain_q;
    aborted_d   = aborted_q;
    s1_valid_d  = 1'b0;
    s1_off_d    = '0;
    src_rd_en_d = 1'b0;
    src_addr_d  = '0;
    // Stage 2 registers whatever stage 1 held; read data is valid this cycle.
    dst_we_d    = s1_valid_q;
    dst_addr_d  = s1_valid_q ? (dst_base_q + s1_off_q) : '0;
    dst_wdata_d = (s1_valid_q && !zero_q) ? src_rd_data_i : '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d      = len_i;
          zero_d     = zero_i;
          src_base_d = src_base_i;
          dst_base_d = dst_base_i;
          aborted_d  = 1'b0;
          if (len_i == '0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_ISSUE;
            rd_cnt_d    = ONE_L;
            src_rd_en_d = !zero_i;
            src_addr_d  = zero_i ? '0 : src_base_i;
          end
        end
      end
      S_ISSUE: begin
        if (abort_i) begin
          state_d   = S_DONE;
          aborted_d = 1'b0 | 1'b1;
        end else begin
          // rd_cnt counts slots already on the bus, so this slot's offset is one less.
          s1_valid_d = 1'b1;
          s1_off_d   = rd_cnt_q[ADDR_W-1:0] - ONE_A;
          if (rd_cnt_q == len_q) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end else begin
            rd_cnt_d    = rd_cnt_q + ONE_L;
            src_rd_en_d = !zero_q;
            src_addr_d  = zero_q ? '0 : (src_base_q + rd_cnt_q[ADDR_W-1:0]);
          end
        end
      end
      S_DRAIN: begin
        if (abort_i) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (drain_q) begin
          state_d = S_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (aborted_d && !aborted_q && state_q != S_IDLE) begin
      dst_we_d    = 1'b0;
      dst_addr_d  = '0;
      dst_wdata_d = '0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      len_q       <= '0;
      zero_q      <= 1'b0;
      src_base_q  <= '0;
      dst_base_q  <= '0;
      drain_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_off_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      src_rd_en_q <= 1'b0;
      src_addr_q  <= '0;
      dst_we_q    <= 1'b0;
      dst_addr_q  <= '0;
      dst_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      len_q       <= len_d;
      zero_q      <= zero_d;
      src_base_q  <= src_base_d;
      dst_base_q  <= dst_base_d;
      drain_q     <= drain_d;
      s1_valid_q  <= s1_valid_d;
      s1_off_q    <= s1_off_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      src_rd_en_q <= src_rd_en_d;
      src_addr_q  <= src_addr_d;
      dst_we_q    <= dst_we_d;
      dst_addr_q  <= dst_addr_d;
      dst_wdata_q <= dst_wdata_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign src_rd_en_o = src_rd_en_q;
  assign src_addr_o  = src_addr_q;
  assign dst_we_o    = dst_we_q;
  assign dst_addr_o  = dst_addr_q;
  assign dst_wdata_o = dst_wdata_q;

endmodule

// File: tb/tb_abr_mem_copy_engine.sv
// Directed bench for abr_mem_copy_engine: table of transfers checked cycle by
// cycle against the documented timing, plus reset-during-transfer sequence.
module tb_abr_mem_copy_engine;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 96;
  localparam int LEN_W  = 11;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              zero_i;
  logic [ADDR_W-1:0] src_base_i;
  logic [ADDR_W-1:0] dst_base_i;
  logic [LEN_W-1:0]  len_i;
  logic              abort_i;
  logic              busy_o, done_o, aborted_o;
  logic              src_rd_en_o;
  logic [ADDR_W-1:0] src_addr_o;
  logic [DATA_W-1:0] src_rd_data;
  logic              dst_we_o;
  logic [ADDR_W-1:0] dst_addr_o;
  logic [DATA_W-1:0] dst_wdata_o;

  logic [DATA_W-1:0] srcmem [1024];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  abr_mem_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .zero_i(zero_i),
    .src_base_i(src_base_i), .dst_base_i(dst_base_i), .len_i(len_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
    .src_rd_en_o(src_rd_en_o), .src_addr_o(src_addr_o),
    .src_rd_data_i(src_rd_data), .dst_we_o(dst_we_o), .dst_addr_o(dst_addr_o),
    .dst_wdata_o(dst_wdata_o)
  );

  // Single-cycle-latency source SRAM.
  always @(posedge clk) begin
    if (src_rd_en_o) src_rd_data <= srcmem[src_addr_o];
  end

  typedef struct {
    logic              zero;
    logic [ADDR_W-1:0] sb;
    logic [ADDR_W-1:0] db;
    logic [LEN_W-1:0]  len;
    int                abort_k;     // cycle with abort_i high, 0 = none
    int                busy_start;  // cycle with a stray start, 0 = none
    logic              start_abort; // abort_i high together with start
    int                exp_done;    // cycle of done_o
    int                exp_nwr;     // number of destination writes
    logic              exp_ab;      // aborted_o after completion
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input int cyc, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int rdlast, wrlast, donec, meas_done, nwr, n;
    logic [ADDR_W-1:0] ea;
    logic [ADDR_W-1:0] eoff;
    logic erd, ewe;
    v = vecs[idx];
    n = int'(v.len);
    if (v.abort_k > 0) begin
      rdlast = (n < v.abort_k) ? n : v.abort_k;
      wrlast = ((n + 2) < v.abort_k) ? n + 2 : v.abort_k;
      donec  = v.abort_k + 1;
    end else begin
      rdlast = n;
      wrlast = n + 2;
      donec  = (n == 0) ? 1 : n + 3;
    end
    // cycle 0
    zero_i = v.zero; src_base_i = v.sb; dst_base_i = v.db; len_i = v.len;
    start_i = 1'b1; abort_i = v.start_abort;
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
    src_base_i = 10'h155; dst_base_i = 10'h2AA; len_i = 11'd7; zero_i = ~v.zero;
    meas_done = -1; nwr = 0;
    for (int c = 1; c <= donec + 1; c++) begin
      erd = !v.zero && (c <= rdlast);
      ewe = (c >= 3) && (c <= wrlast);
      chk("busy", c, DATA_W'(busy_o), DATA_W'(c <= donec));
      chk("done", c, DATA_W'(done_o), DATA_W'(c == donec));
      chk("aborted", c, DATA_W'(aborted_o), DATA_W'((v.abort_k > 0) && (c > v.abort_k)));
      chk("src_rd_en", c, DATA_W'(src_rd_en_o), DATA_W'(erd));
      ea = v.sb + ADDR_W'(c - 1);
      chk("src_addr", c, DATA_W'(src_addr_o), erd ? DATA_W'(ea) : '0);
      chk("dst_we", c, DATA_W'(dst_we_o), DATA_W'(ewe));
      eoff = ADDR_W'(c - 3);
      ea = v.db + eoff;
      chk("dst_addr", c, DATA_W'(dst_addr_o), ewe ? DATA_W'(ea) : '0);
      ea = v.sb + eoff;
      chk("dst_wdata", c, dst_wdata_o, (ewe && !v.zero) ? srcmem[ea] : '0);
      if (done_o && meas_done < 0) meas_done = c;
      if (dst_we_o) nwr++;
      abort_i = (c == v.abort_k);
      start_i = (c == v.busy_start);
      if (c <= donec) begin
        @(posedge clk); #1;
      end
    end
    abort_i = 1'b0; start_i = 1'b0;
    chk("done_cycle", idx, DATA_W'(meas_done), DATA_W'(v.exp_done));
    chk("write_count", idx, DATA_W'(nwr), DATA_W'(v.exp_nwr));
    chk("aborted_final", idx, DATA_W'(aborted_o), DATA_W'(v.exp_ab));
    $display("vec %0d: zero=%0d src=%h dst=%h len=%0d -> done cycle %0d, %0d writes, aborted=%0d",
             idx, v.zero, v.sb, v.db, v.len, meas_done, nwr, aborted_o);
  endtask

  task automatic chk_all_zero(input string tag, input int cyc);
    chk({tag, "_busy"}, cyc, DATA_W'(busy_o), '0);
    chk({tag, "_done"}, cyc, DATA_W'(done_o), '0);
    chk({tag, "_aborted"}, cyc, DATA_W'(aborted_o), '0);
    chk({tag, "_rd_en"}, cyc, DATA_W'(src_rd_en_o), '0);
    chk({tag, "_src_addr"}, cyc, DATA_W'(src_addr_o), '0);
    chk({tag, "_we"}, cyc, DATA_W'(dst_we_o), '0);
    chk({tag, "_dst_addr"}, cyc, DATA_W'(dst_addr_o), '0);
    chk({tag, "_wdata"}, cyc, dst_wdata_o, '0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      srcmem[i] = {32'hC0DE_0000 + 32'(i), 32'(i) * 32'h0101_0101, ~32'(i)};
    src_rd_data = '0;

    //           zero  sb      db      len    abk bs sa done nwr ab
    vecs[0] = '{1'b0, 10'h010, 10'h020, 11'd4, 0, 0, 1'b0, 7, 4, 1'b0};
    vecs[1] = '{1'b0, 10'h3FE, 10'h3FF, 11'd3, 0, 0, 1'b0, 6, 3, 1'b0};
    vecs[2] = '{1'b1, 10'h050, 10'h100, 11'd5, 0, 0, 1'b0, 8, 5, 1'b0};
    vecs[3] = '{1'b0, 10'h123, 10'h321, 11'd0, 0, 0, 1'b0, 1, 0, 1'b0};
    vecs[4] = '{1'b0, 10'h200, 10'h300, 11'd8, 4, 0, 1'b0, 5, 2, 1'b1};
    vecs[5] = '{1'b0, 10'h3FF, 10'h000, 11'd2, 0, 0, 1'b0, 5, 2, 1'b0};
    vecs[6] = '{1'b0, 10'h0A0, 10'h0B0, 11'd1, 3, 0, 1'b0, 4, 1, 1'b1};
    vecs[7] = '{1'b0, 10'h001, 10'h002, 11'd2, 0, 0, 1'b1, 5, 2, 1'b0};
    vecs[8] = '{1'b0, 10'h040, 10'h060, 11'd3, 0, 2, 1'b0, 6, 3, 1'b0};

    rst_i = 1'b1; start_i = 1'b0; zero_i = 1'b0; abort_i = 1'b0;
    src_base_i = '0; dst_base_i = '0; len_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset", 0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Reset asserted in cycle 3 of a len=8 copy.
    zero_i = 1'b0; src_base_i = 10'h000; dst_base_i = 10'h080; len_i = 11'd8;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_busy", 3, DATA_W'(busy_o), DATA_W'(1));
    rst_i = 1'b1;
    #1;
    chk_all_zero("midreset", 3);
    @(posedge clk); #1;
    rst_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("post_reset_done", c, DATA_W'(done_o), '0);
      chk("post_reset_we", c, DATA_W'(dst_we_o), '0);
      @(posedge clk); #1;
    end
    $display("reset seq: outputs cleared mid-transfer, no completion pulse");
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
